// File: rtl/shift_rows_pipe_pkg.sv
// Shared definitions for the ShiftRows pipeline: row offsets, byte placement
// and the legal parameter ranges.
package shift_rows_pipe_pkg;

   localparam int ROWS = 4;

   // Rijndael row offsets; wide (NB=8) states skip offset 2.
   function automatic int off(input int nb, input int r);
      if (nb == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   function automatic int byte_idx(input int c, input int r);
      return ROWS * c + r;
   endfunction

   function automatic bit nb_ok(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 1) && (depth <= 4);
   endfunction

endpackage

// File: rtl/shift_rows_pipe_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module shift_rows_perm
   import shift_rows_pipe_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [32*NB-1:0] data_in,
   input  logic             inv,
   output logic [32*NB-1:0] data_out
);

   localparam int W = 32 * NB;

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         localparam int FWD_SRC = (c + off(NB, r)) % NB;
         localparam int INV_SRC = (c - off(NB, r) + NB) % NB;
         localparam int DST     = W - 1 - 8 * byte_idx(c, r);
         localparam int FWD_BIT = W - 1 - 8 * byte_idx(FWD_SRC, r);
         localparam int INV_BIT = W - 1 - 8 * byte_idx(INV_SRC, r);

         assign data_out[DST -: 8] = inv ? data_in[INV_BIT -: 8] : data_in[FWD_BIT -: 8];
      end
   end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows permutation followed by a DEPTH-stage valid/ready pipeline that
// carries a sideband tag and counts delivered blocks.
module shift_rows_pipe
   import shift_rows_pipe_pkg::*;
#(
   parameter int NB    = 4,
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_inv,
   input  logic [32*NB-1:0]     in_data,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [32*NB-1:0]     out_data,
   output logic [TAG_W-1:0]     out_tag,
   output logic [15:0]          blk_count
);

   localparam int W = 32 * NB;

   if (!nb_ok(NB)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("shift_rows_pipe: DEPTH must be in 1..4");
   end

   logic [W-1:0]     w_perm;
   logic [DEPTH-1:0] w_load;
   logic [DEPTH-1:0] r_vld;
   logic [W-1:0]     r_data [DEPTH];
   logic [TAG_W-1:0] r_tag  [DEPTH];
   logic [15:0]      r_blk_cnt;

   shift_rows_perm #(.NB(NB)) u_perm (
      .data_in  (in_data),
      .inv      (in_inv),
      .data_out (w_perm)
   );

   // A stage may load if it or any stage after it has room, or the sink takes the head.
   always_comb begin
      logic v_room;
      v_room = out_ready;
      w_load = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         v_room    = v_room || !r_vld[i];
         w_load[i] = v_room;
      end
   end

   assign in_ready = rst_n && !flush && w_load[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld     <= '0;
         r_blk_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
            r_tag[i]  <= '0;
         end
      end else if (flush) begin
         r_vld <= '0;
      end else begin
         if (r_vld[DEPTH-1] && out_ready) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
         end
         if (w_load[0]) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
               r_data[0] <= w_perm;
               r_tag[0]  <= in_tag;
            end
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (w_load[i]) begin
               r_vld[i] <= r_vld[i-1];
               if (r_vld[i-1]) begin
                  r_data[i] <= r_data[i-1];
                  r_tag[i]  <= r_tag[i-1];
               end
            end
         end
      end
   end

   assign out_valid = r_vld[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign out_tag   = r_tag[DEPTH-1];
   assign blk_count = r_blk_cnt;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4/DEPTH=2, NB=6/DEPTH=3 and NB=8/DEPTH=1 instances.
module tb_shift_rows_pipe;

   localparam int TW = 4;
   localparam int OFF8 [4] = '{0, 1, 3, 4};

   typedef struct {
      logic [255:0]  d;
      logic [TW-1:0] t;
      int            acc;
      bit            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic [2:0]           flush_v, vin_v, inv_v, ordy_v, rdy_v, ov_v;
   logic [2:0][255:0]    din_v, od_v;
   logic [2:0][TW-1:0]   tin_v, ot_v;
   logic [2:0][15:0]     cnt_v;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   task automatic push_exp(input int g, input exp_t e);
      case (g)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pop_exp(input int g, output exp_t e, output bit ok);
      ok = 1'b0;
      e.d = '0; e.t = '0; e.acc = 0; e.lat = 1'b0;
      case (g)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   function automatic int qsize(input int g);
      case (g)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   // Reference: unpack the state into a 4 x NB byte matrix, rotate each row, repack.
   function automatic logic [255:0] ref_shift(input int nb, input bit inv, input logic [255:0] d);
      logic [7:0]   st [4][8];
      logic [7:0]   o  [4][8];
      logic [255:0] res;
      int           w, sh, src;
      w   = 32 * nb;
      res = '0;
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = d[w-1-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) begin
         sh = (nb == 8) ? OFF8[r] : r;
         for (int c = 0; c < nb; c++) begin
            src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
            o[r][c] = st[r][src];
         end
      end
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            res[w-1-8*(4*c+r) -: 8] = o[r][c];
      return res;
   endfunction

   function automatic logic [255:0] rnd(input int nb);
      logic [255:0] v;
      logic [255:0] mask;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      mask = (256'd1 << (32 * nb)) - 256'd1;
      if (nb == 8) mask = '1;
      return v & mask;
   endfunction

   task automatic chk_b(input string nm, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%b required=%b", nm, act, req);
      end
   endtask

   task automatic chk_w(input string nm, input logic [255:0] act, input logic [255:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int NBG = (g == 0) ? 4 : ((g == 1) ? 6 : 8);
      localparam int DG  = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
      localparam int WG  = 32 * NBG;

      logic [WG-1:0] w_od;
      logic [WG-1:0] last_od;
      logic          w_rdy, w_ov;
      logic [TW-1:0] w_ot;
      logic [15:0]   w_cnt;
      exp_t          m_e;
      bit            m_ok;

      shift_rows_pipe #(.NB(NBG), .DEPTH(DG), .TAG_W(TW)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush_v[g]),
         .in_valid  (vin_v[g]),
         .in_ready  (w_rdy),
         .in_inv    (inv_v[g]),
         .in_data   (din_v[g][WG-1:0]),
         .in_tag    (tin_v[g]),
         .out_valid (w_ov),
         .out_ready (ordy_v[g]),
         .out_data  (w_od),
         .out_tag   (w_ot),
         .blk_count (w_cnt)
      );

      assign rdy_v[g] = w_rdy;
      assign ov_v[g]  = w_ov;
      assign od_v[g]  = 256'(w_od);
      assign ot_v[g]  = w_ot;
      assign cnt_v[g] = w_cnt;

      initial forever begin
         @(negedge clk);
         if (rst_n && !flush_v[g] && w_ov && ordy_v[g]) begin
            pop_exp(g, m_e, m_ok);
            total++;
            if (!m_ok) begin
               bad++;
               $display("FAIL out_unexpected[%0d] data=%h tag=%0d required=no block", g, w_od, w_ot);
            end else begin
               if (256'(w_od) !== m_e.d || w_ot !== m_e.t) begin
                  bad++;
                  $display("FAIL out_block[%0d] data=%h tag=%0d required data=%h tag=%0d",
                           g, w_od, w_ot, m_e.d[WG-1:0], m_e.t);
               end
               if (m_e.lat) begin
                  total++;
                  if (cyc - m_e.acc != DG) begin
                     bad++;
                     $display("FAIL latency[%0d] actual=%0d required=%0d", g, cyc - m_e.acc, DG);
                  end
               end
            end
            last_od = w_od;
         end
      end
   end

   // Caller is just after a rising edge; returns just after the accepting edge.
   task automatic send(input int g, input bit inv, input logic [255:0] d, input logic [TW-1:0] t,
                       input logic [255:0] exp_d, input bit lat);
      exp_t e;
      vin_v[g] = 1'b1;
      inv_v[g] = inv;
      din_v[g] = d;
      tin_v[g] = t;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (rdy_v[g]) begin
            e.d = exp_d; e.t = t; e.acc = cyc; e.lat = lat;
            push_exp(g, e);
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      total++; bad++;
      $display("FAIL send_timeout[%0d] in_ready=0 required=1", g);
      vin_v[g] = 1'b0;
   endtask

   task automatic drain(input int g);
      for (int n = 0; n < 200; n++) begin
         if (qsize(g) == 0) return;
         @(posedge clk); #1;
      end
      total++; bad++;
      $display("FAIL drain_timeout[%0d] pending=%0d required=0", g, qsize(g));
   endtask

   localparam logic [255:0] V44     = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] V44_INV = 256'h000d0a0704010e0b0805020f0c090603;
   localparam logic [255:0] V44_FWD = 256'h00050a0f04090e03080d02070c01060b;

   logic [255:0] x, y, held, idx8;
   logic [15:0]  c0, want;
   bit           iv, drv_done;
   exp_t         e_tmp;

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      flush_v = '0; vin_v = '0; inv_v = '0; ordy_v = '1; din_v = '0; tin_v = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_b("rst_out_valid", ov_v[0], 1'b0);
      chk_b("rst_in_ready", rdy_v[0], 1'b0);
      chk_w("rst_blk_count", 256'(cnt_v[0]), 256'd0);
      chk_w("rst_out_data", od_v[0], 256'd0);
      chk_w("rst_out_tag", 256'(ot_v[0]), 256'd0);
      rst_n = 1'b1;

      send(0, 1'b1, V44, 4'd1, V44_INV, 1'b1); vin_v[0] = 1'b0; drain(0);
      send(0, 1'b0, V44, 4'd2, V44_FWD, 1'b1); vin_v[0] = 1'b0; drain(0);
      for (int i = 1; i <= 4; i++)
         send(0, i[0], V44, i[TW-1:0], i[0] ? V44_INV : V44_FWD, 1'b1);
      vin_v[0] = 1'b0; drain(0);

      // Stall a 6-block burst behind out_ready low.
      ordy_v[0] = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               x = rnd(4); iv = 1'($urandom % 2);
               send(0, iv, x, 4'(5 + i), ref_shift(4, iv, x), 1'b0);
            end
            vin_v[0] = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk_b("stall_in_ready", rdy_v[0], 1'b0);
            chk_b("stall_out_valid", ov_v[0], 1'b1);
            held = od_v[0];
            repeat (5) begin
               @(negedge clk);
               chk_w("stall_out_data_stable", od_v[0], held);
               chk_b("stall_out_valid_held", ov_v[0], 1'b1);
            end
            @(posedge clk); #1;
            ordy_v[0] = 1'b1;
         end
      join
      drain(0);

      // Mixed-mode random traffic with random backpressure.
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               x = rnd(4); iv = 1'($urandom % 2);
               send(0, iv, x, i[TW-1:0], ref_shift(4, iv, x), 1'b0);
               if ($urandom % 3 == 0) begin
                  vin_v[0] = 1'b0;
                  @(posedge clk); #1;
               end
            end
            vin_v[0] = 1'b0;
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk); #1;
               ordy_v[0] = 1'($urandom % 2);
            end
            ordy_v[0] = 1'b1;
         end
      join
      drain(0);

      // Forward then inverse must return the original block.
      for (int g = 1; g <= 2; g++) begin
         for (int i = 0; i < 12; i++) begin
            x = rnd((g == 1) ? 6 : 8);
            y = ref_shift((g == 1) ? 6 : 8, 1'b0, x);
            send(g, 1'b0, x, i[TW-1:0], y, 1'b0);
            send(g, 1'b1, y, i[TW-1:0], x, 1'b0);
         end
         vin_v[g] = 1'b0;
         drain(g);
      end
      for (int k = 0; k < 32; k++) idx8[255-8*k -: 8] = 8'(k);
      send(2, 1'b0, idx8, 4'd9, ref_shift(8, 1'b0, idx8), 1'b0);
      vin_v[2] = 1'b0; drain(2);
      chk_w("nb8_row2_col0", 256'(g_dut[2].last_od[255-8*2 -: 8]), 256'h0e);
      chk_w("nb8_row2_col1", 256'(g_dut[2].last_od[255-8*6 -: 8]), 256'h12);

      // Flush with two blocks in flight, plus a competing input and output handshake.
      ordy_v[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         x = rnd(4);
         send(0, 1'b0, x, 4'(i), ref_shift(4, 1'b0, x), 1'b0);
      end
      c0 = cnt_v[0];
      flush_v[0] = 1'b1; ordy_v[0] = 1'b1; vin_v[0] = 1'b1; din_v[0] = rnd(4);
      @(negedge clk);
      chk_b("flush_in_ready", rdy_v[0], 1'b0);
      @(posedge clk); #1;
      flush_v[0] = 1'b0; vin_v[0] = 1'b0;
      q0.delete();
      @(negedge clk);
      chk_b("flush_out_valid", ov_v[0], 1'b0);
      chk_w("flush_blk_count", 256'(cnt_v[0]), 256'(c0));
      repeat (3) @(negedge clk);
      chk_b("flush_no_accept", ov_v[0], 1'b0);

      // Asynchronous reset in the middle of a burst.
      @(posedge clk); #1;
      x = rnd(4);
      vin_v[0] = 1'b1; inv_v[0] = 1'b0; din_v[0] = x; tin_v[0] = 4'd3;
      e_tmp.d = ref_shift(4, 1'b0, x); e_tmp.t = 4'd3; e_tmp.acc = 0; e_tmp.lat = 1'b0;
      push_exp(0, e_tmp);
      @(posedge clk); #1;
      din_v[0] = rnd(4);
      e_tmp.d = ref_shift(4, 1'b0, din_v[0]);
      push_exp(0, e_tmp);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk_b("async_rst_out_valid", ov_v[0], 1'b0);
      chk_w("async_rst_blk_count", 256'(cnt_v[0]), 256'd0);
      chk_b("async_rst_in_ready", rdy_v[0], 1'b0);
      vin_v[0] = 1'b0;
      q0.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk_b("post_rst_in_ready", rdy_v[0], 1'b1);
      x = rnd(4);
      send(0, 1'b1, x, 4'd7, ref_shift(4, 1'b1, x), 1'b1);
      vin_v[0] = 1'b0; drain(0);
      chk_w("post_rst_blk_count", 256'(cnt_v[0]), 256'd1);

      // Counter wrap: reach 0xFFFE deliveries, then three more.
      for (int i = 0; i < 65533; i++) begin
         x = rnd(4);
         send(0, i[0], x, i[TW-1:0], ref_shift(4, i[0], x), 1'b0);
      end
      vin_v[0] = 1'b0; drain(0);
      chk_w("cnt_preload", 256'(cnt_v[0]), 256'hFFFE);
      want = 16'hFFFE;
      for (int k = 0; k < 3; k++) begin
         x = rnd(4);
         send(0, 1'b0, x, 4'(k), ref_shift(4, 1'b0, x), 1'b0);
         vin_v[0] = 1'b0; drain(0);
         want = want + 16'd1;
         chk_w("cnt_wrap", 256'(cnt_v[0]), 256'(want));
      end

      repeat (4) @(posedge clk);
      chk_w("q0_empty", 256'(q0.size()), 256'd0);
      chk_w("q1_empty", 256'(q1.size()), 256'd0);
      chk_w("q2_empty", 256'(q2.size()), 256'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns (4, 6 or 8; block width W = 32*NB bits).
REQ-002 SHALL have parameter DEPTH, default 2, meaning pipeline register stages (1..4).
REQ-003 SHALL have parameter TAG_W, default 4, meaning sideband tag width carried alongside each block.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 in_valid  input  1  input block present.
REQ-008 in_ready  output  1  block accepted when in_valid and in_ready are both high.
REQ-009 in_inv  input  1  1 = inverse ShiftRows (decrypt), 0 = forward ShiftRows (encrypt), sampled per block.
REQ-010 in_data  input  W  state, column-major; byte k = 4*c + r occupies bits [W-1-8k -: 8].
REQ-011 in_tag  input  TAG_W  sideband, returned unchanged with its block.
REQ-012 out_valid  output  1  output block present.
REQ-013 out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
REQ-014 out_data  output  W  shifted state.
REQ-015 out_tag  output  TAG_W  tag of the block on out_data.
REQ-016 blk_count  output  16  number of blocks delivered at the output since reset, wrapping.

Function
REQ-017 Row offsets SHALL be off(r) = {0,1,2,3} for NB = 4 or 6, and {0,1,3,4} for NB = 8.
REQ-018 Forward SHALL compute out[r][c] = in[r][(c + off(r)) mod NB].
REQ-019 Inverse SHALL compute out[r][c] = in[r][(c - off(r)) mod NB].
REQ-020 The permutation SHALL be applied before the first register stage; the remaining stages only carry data, tag and valid.
REQ-021 Latency SHALL be exactly DEPTH cycles from acceptance to out_valid when out_ready stays high.
REQ-022 Throughput SHALL be one block per cycle with no bubbles while out_ready stays high.
REQ-023 Each stage SHALL load when it is empty or when its successor advances in the same cycle.
REQ-024 in_ready SHALL equal "stage 1 can load" and SHALL NOT depend combinationally on in_valid.
REQ-025 When out_valid is high and out_ready is low, out_data and out_tag SHALL hold stable and out_valid SHALL stay high.
REQ-026 Blocks SHALL never be dropped, duplicated or reordered.
REQ-027 A block whose stage is full and stalled SHALL not be overwritten.
REQ-028 When all stages are full and out_ready is low, in_ready SHALL be 0.
REQ-029 A simultaneous output handshake and input acceptance SHALL be handled in the same cycle.
REQ-030 in_inv SHALL be honoured per block, so mixed-mode traffic produces correctly shifted blocks.
REQ-031 flush SHALL clear all stage valid bits on the next edge and discard all in-flight blocks.
REQ-032 flush SHALL force in_ready low for that cycle and SHALL leave blk_count unchanged.
REQ-033 flush SHALL take priority over a simultaneous input or output handshake; an output handshake in that cycle is not counted.
REQ-034 blk_count SHALL increment on each out_valid and out_ready handshake and wrap from 0xFFFF to 0x0000.

Reset
REQ-035 While rst_n is low, all stage valid bits, out_valid and blk_count SHALL be 0 immediately.
REQ-036 While rst_n is low, in_ready SHALL be 0.
REQ-037 out_data and out_tag SHALL reset to 0.
REQ-038 Reset asserted mid-stream SHALL discard all in-flight blocks.
REQ-039 The first acceptance after deassertion SHALL be possible on the first clk edge with rst_n high.

Structure
REQ-040 A shared package SHALL hold the offset function off(nb, r), the byte-index helper and the legal NB/DEPTH checks.
REQ-041 Elaboration SHALL fail on NB outside {4,6,8} or DEPTH outside 1..4.
REQ-042 The combinational permutation SHALL be one sub-module, shift_rows_perm (parameters NB; ports data_in, inv, data_out).
REQ-043 The pipeline and handshake SHALL be in the top module.

Verification
REQ-044 NB=4, DEPTH=2, inverse, in_data 000102030405060708090a0b0c0d0e0f -> out_data 000d0a0704010e0b0805020f0c090603 exactly 2 cycles after acceptance.
REQ-045 Same input with in_inv=0 -> out_data 00050a0f04090e03080d02070c01060b; back-to-back alternating modes with tags 1,2,3,4 -> outputs alternate correctly, tags in order 1,2,3,4.
REQ-046 Stall: out_ready low for 5 cycles during a 6-block burst -> in_ready falls once DEPTH blocks are held, out_data stable, all 6 blocks later delivered in order.
REQ-047 Forward then inverse round trip on random blocks for NB = 6 and NB = 8 -> output equals original input; NB=8 row 2 of a single block rotates by 3 columns.
REQ-048 flush with 2 blocks in flight -> out_valid 0 next cycle, blk_count unchanged; rst_n pulse mid-burst -> out_valid and blk_count 0 asynchronously.
REQ-049 Preload blk_count to 0xFFFE by 0xFFFE handshakes, then deliver 3 blocks -> blk_count reads 0xFFFF, 0x0000, 0x0001.
